// File: rtl/commit_trace_buffer_if.sv
// Trace stream from commit_trace_buffer to a trace sink: one retired-instruction record per beat,
// valid/ready handshake.
interface commit_trace_buffer_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic [4:0]      rd;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [1:0]      priv;
  logic            v;
  logic [31:0]     seq;
  logic            gap;

  modport master (
    output valid, pc, instr, rd, we, wdata, priv, v, seq, gap,
    input  ready
  );

  modport slave (
    input  valid, pc, instr, rd, we, wdata, priv, v, seq, gap,
    output ready
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit-stage trace capture FIFO: tags retired records with sequence numbers, drops whole groups
// on overflow. Define TRACE_FILTER_EN to enable per-privilege filtering via filter_mask_i.
module commit_trace_buffer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 8,
  parameter int unsigned XLEN          = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NrCommitPorts-1:0]            commit_valid_i,
  input  logic [NrCommitPorts-1:0][XLEN-1:0]  commit_pc_i,
  input  logic [NrCommitPorts-1:0][31:0]      commit_instr_i,
  input  logic [NrCommitPorts-1:0][4:0]       commit_rd_i,
  input  logic [NrCommitPorts-1:0]            commit_we_i,
  input  logic [NrCommitPorts-1:0][XLEN-1:0]  commit_wdata_i,
  input  logic [1:0]                          priv_lvl_i,
  input  logic                                v_i,
  input  logic [3:0]                          filter_mask_i,
  commit_trace_buffer_if.master               trace_o,
  output logic [31:0]                         drop_cnt_o,
  output logic                                full_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = $clog2(NrCommitPorts + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [1:0]      priv;
    logic            v;
    logic [31:0]     seq;
    logic            gap;
  } rec_t;

  rec_t                              mem_q [Depth];
  logic [AW-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                     count_q, count_d;
  logic [31:0]                       seq_q, seq_d, drop_q, drop_d;
  logic                              gap_q, gap_d;
  logic                              filter_ok;
  logic [NrCommitPorts-1:0]          elig;
  logic [NrCommitPorts-1:0][LW-1:0]  slot;
  logic [NrCommitPorts-1:0][31:0]    lane_seq;
  logic [LW-1:0]                     n_elig, n_valid;
  logic                              accept, push, pop;
  logic [32:0]                       drop_sum;

`ifdef TRACE_FILTER_EN
  assign filter_ok = filter_mask_i[priv_lvl_i];
`else
  logic unused_filter;
  assign unused_filter = ^filter_mask_i;
  assign filter_ok     = 1'b1;
`endif

  assign elig = commit_valid_i & {NrCommitPorts{filter_ok}};

  // Sequence rank counts every valid lane; storage slot counts only eligible lanes.
  always_comb begin
    n_elig   = '0;
    n_valid  = '0;
    slot     = '0;
    lane_seq = '0;
    for (int unsigned k = 0; k < NrCommitPorts; k++) begin
      slot[k]     = n_elig;
      lane_seq[k] = seq_q + 32'(n_valid);
      if (commit_valid_i[k]) n_valid = n_valid + LW'(1);
      if (elig[k])           n_elig  = n_elig + LW'(1);
    end
  end

  assign pop      = (count_q != '0) && trace_o.ready;
  // Space is judged on the start-of-cycle count; a same-cycle pop does not help.
  assign accept   = CW'(n_elig) <= (CW'(Depth) - count_q);
  assign push     = accept && !flush_i;
  assign drop_sum = {1'b0, drop_q} + 33'(n_elig);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    gap_d    = gap_q;
    seq_d    = seq_q + 32'(n_valid);
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(n_elig);
      if (n_elig != '0) gap_d = 1'b0;
    end else begin
      drop_d = drop_sum[32] ? '1 : drop_sum[31:0];
      if (n_elig != '0) gap_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (push ? CW'(n_elig) : '0) - (pop ? CW'(1) : '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      gap_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      gap_q    <= gap_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push) begin
      for (int unsigned k = 0; k < NrCommitPorts; k++) begin
        if (elig[k]) begin
          mem_q[wr_ptr_q + AW'(slot[k])] <= '{
            pc:    commit_pc_i[k],
            instr: commit_instr_i[k],
            rd:    commit_rd_i[k],
            we:    commit_we_i[k],
            wdata: commit_wdata_i[k],
            priv:  priv_lvl_i,
            v:     v_i,
            seq:   lane_seq[k],
            gap:   gap_q && (slot[k] == '0)
          };
        end
      end
    end
  end

  assign trace_o.valid = count_q != '0;
  assign trace_o.pc    = mem_q[rd_ptr_q].pc;
  assign trace_o.instr = mem_q[rd_ptr_q].instr;
  assign trace_o.rd    = mem_q[rd_ptr_q].rd;
  assign trace_o.we    = mem_q[rd_ptr_q].we;
  assign trace_o.wdata = mem_q[rd_ptr_q].wdata;
  assign trace_o.priv  = mem_q[rd_ptr_q].priv;
  assign trace_o.v     = mem_q[rd_ptr_q].v;
  assign trace_o.seq   = mem_q[rd_ptr_q].seq;
  assign trace_o.gap   = mem_q[rd_ptr_q].gap;
  assign drop_cnt_o    = drop_q;
  assign full_o        = count_q == CW'(Depth);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a reference model queues expected records as commit
// groups are driven and compares them with the head record on each handshake.
module tb_commit_trace_buffer;
  localparam int NP    = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 64;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] wdata;
    logic [1:0]  priv;
    logic        v;
    logic [31:0] seq;
    logic        gap;
  } exp_t;

  logic                      clk, rst_ni, flush;
  logic [NP-1:0]             cv, cwe;
  logic [NP-1:0][XLEN-1:0]   cpc, cwdata;
  logic [NP-1:0][31:0]       cinstr;
  logic [NP-1:0][4:0]        crd;
  logic [1:0]                priv;
  logic                      v;
  logic [3:0]                mask;
  logic [31:0]               drop_cnt;
  logic                      full;

  commit_trace_buffer_if #(.XLEN(XLEN)) trace_if ();

  commit_trace_buffer #(.NrCommitPorts(NP), .Depth(DEPTH), .XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush),
    .commit_valid_i (cv),
    .commit_pc_i    (cpc),
    .commit_instr_i (cinstr),
    .commit_rd_i    (crd),
    .commit_we_i    (cwe),
    .commit_wdata_i (cwdata),
    .priv_lvl_i     (priv),
    .v_i            (v),
    .filter_mask_i  (mask),
    .trace_o        (trace_if),
    .drop_cnt_o     (drop_cnt),
    .full_o         (full)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  int          m_count = 0;
  longint      m_drop  = 0;
  logic [31:0] m_seq   = '0;
  logic        m_gp    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cv = '0; cwe = '0; cpc = '0; cwdata = '0; cinstr = '0; crd = '0;
  endtask

  task automatic set_lane(input int k, input logic [63:0] pc);
    cv[k]     = 1'b1;
    cpc[k]    = pc;
    cinstr[k] = pc[31:0] ^ 32'hA5A5_0013;
    crd[k]    = pc[6:2];
    cwe[k]    = pc[2];
    cwdata[k] = ~pc;
  endtask

  function automatic bit lane_passes();
`ifdef TRACE_FILTER_EN
    return mask[priv];
`else
    return 1'b1;
`endif
  endfunction

  // One clock: check the head against the model, apply the commit group to the model, advance.
  task automatic step();
    exp_t e;
    exp_t stage [NP];
    int   n, nv;
    bit   p;
    check("valid", trace_if.valid, m_count != 0);
    check("full", full, m_count == DEPTH);
    check("drop_cnt", drop_cnt, m_drop[31:0]);
    p = (m_count != 0) && trace_if.ready;
    if (p) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pc", trace_if.pc, e.pc);
        check("instr", trace_if.instr, e.instr);
        check("wdata", trace_if.wdata, e.wdata);
        check("rd_we_priv_v", {trace_if.rd, trace_if.we, trace_if.priv, trace_if.v},
              {e.rd, e.we, e.priv, e.v});
        check("seq", trace_if.seq, e.seq);
        check("gap", trace_if.gap, e.gap);
      end
    end
    n = 0; nv = 0;
    for (int k = 0; k < NP; k++) begin
      if (cv[k]) begin
        if (lane_passes()) begin
          stage[n] = '{pc: cpc[k], instr: cinstr[k], rd: crd[k], we: cwe[k], wdata: cwdata[k],
                       priv: priv, v: v, seq: m_seq + 32'(nv), gap: 1'b0};
          n++;
        end
        nv++;
      end
    end
    if (flush) begin
      m_count = 0;
      sb.delete();
      m_drop  = m_drop + n;
      if (n > 0) m_gp = 1'b1;
    end else if (n <= DEPTH - m_count) begin
      for (int i = 0; i < n; i++) begin
        if (i == 0) stage[i].gap = m_gp;
        sb.push_back(stage[i]);
      end
      if (n > 0) m_gp = 1'b0;
      m_count = m_count + n - int'(p);
    end else begin
      m_drop  = m_drop + n;
      m_gp    = 1'b1;
      m_count = m_count - int'(p);
    end
    if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
    m_seq = m_seq + 32'(nv);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, trace_if.valid, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_drop"}, drop_cnt, 0);
    check({tag, "_pc"}, trace_if.pc, 0);
    check({tag, "_seq"}, trace_if.seq, 0);
    check({tag, "_gap"}, trace_if.gap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0; rst_ni = 0; flush = 0; trace_if.ready = 0;
    priv = 2'd3; v = 0; mask = 4'hF;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_ni = 1;
    @(posedge clk);
    #1;

    // Fill to full with the sink stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      idle(); set_lane(0, 64'h1000 + 8 * i); set_lane(1, 64'h1004 + 8 * i); step();
    end
    idle();
    check("fill_full", full, 1);
    trace_if.ready = 1;
    repeat (9) step();
    check("fill_drained", sb.size(), 0);

    // Seven stored, then a two-lane group that does not fit, then a single lane that does.
    trace_if.ready = 0; priv = 2'd1; v = 1;
    for (int i = 0; i < 3; i++) begin
      idle(); set_lane(0, 64'h2000 + 8 * i); set_lane(1, 64'h2004 + 8 * i); step();
    end
    idle(); set_lane(1, 64'h2040); step();
    idle(); set_lane(0, 64'h2080); set_lane(1, 64'h2084); step();
    idle(); set_lane(0, 64'h2100); step();
    check("drop_after_reject", drop_cnt, 2);
    // Pop and two-lane commit at full: the group still drops.
    trace_if.ready = 1;
    idle(); set_lane(0, 64'h2200); set_lane(1, 64'h2204); step();
    idle();
    repeat (9) step();
    priv = 2'd3; v = 0;

    // Pointer wrap with a toggling sink.
    for (int i = 0; i < 40; i++) begin
      idle();
      if (i % 2 == 0) set_lane((i / 2) % 2, 64'h3000 + 4 * i);
      trace_if.ready = logic'(i % 2);
      step();
    end
    trace_if.ready = 1; idle();
    repeat (3) step();

    // Flush with a commit in the same cycle.
    trace_if.ready = 0;
    idle(); set_lane(0, 64'h4000); set_lane(1, 64'h4004); step();
    idle(); set_lane(0, 64'h4008); set_lane(1, 64'h400C); step();
    idle(); set_lane(1, 64'h4010); step();
    flush = 1; idle(); set_lane(0, 64'h4020); step();
    flush = 0; idle(); step();
    idle(); set_lane(0, 64'h4100); step();
    trace_if.ready = 1; idle();
    repeat (3) step();

    // Privilege filter: U-mode record then M-mode record with only M enabled.
    trace_if.ready = 0; mask = 4'b1000;
    priv = 2'd0; idle(); set_lane(0, 64'h5000); step();
    priv = 2'd3; idle(); set_lane(1, 64'h5004); step();
    trace_if.ready = 1; idle();
    repeat (3) step();
    mask = 4'hF;

    // Asynchronous reset in the middle of traffic.
    trace_if.ready = 0;
    idle(); set_lane(0, 64'h6000); set_lane(1, 64'h6004); step();
    idle(); set_lane(0, 64'h6008); step();
    #2 rst_ni = 0;
    #1;
    check_zero("midreset");
    sb.delete(); m_count = 0; m_drop = 0; m_seq = '0; m_gp = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1;
    idle(); set_lane(1, 64'h7000); step();
    trace_if.ready = 1; idle();
    repeat (2) step();

    check("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
